// File: rtl/uart_disp_sched.sv
// rtl/uart_disp_sched.sv - UART-to-display byte scheduler
// Queues received bytes and shows each one on disp_data for HOLD cycles, back-to-back.
module uart_disp_sched #(
  parameter int HOLD  = 25_000_000,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  input  logic          ovf_clr,
  output logic [7:0]    disp_data,
  output logic          disp_busy,
  output logic [AW:0]   fifo_cnt,
  output logic          ovf
);

  localparam logic [24:0] HOLD_LAST = 25'(HOLD - 1);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state_q, state_d;
  logic [24:0]   hold_q, hold_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic empty, full, hold_done;
  logic pop, push, drop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign hold_done = (hold_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      disp_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = SHOW;
      SHOW: if (hold_done && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = !empty && ((state_q == IDLE) || ((state_q == SHOW) && hold_done));
    push = rx_vld && (!full || pop);
    drop = rx_vld && full && !pop;

    hold_d = '0;
    if ((state_q == SHOW) && !hold_done) begin
      hold_d = hold_q + 25'd1;
    end

    disp_d   = pop ? mem_q[rd_ptr_q] : disp_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  assign disp_data = disp_q;
  assign disp_busy = (state_q == SHOW);
  assign fifo_cnt  = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_uart_disp_sched.sv
// tb/tb_uart_disp_sched.sv - directed bench for uart_disp_sched
// Runs with HOLD=8, DEPTH=4.
module tb_uart_disp_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] disp_data;
  logic       disp_busy;
  logic [2:0] fifo_cnt;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  uart_disp_sched #(.HOLD(8), .DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .ovf_clr   (ovf_clr),
    .disp_data (disp_data),
    .disp_busy (disp_busy),
    .fifo_cnt  (fifo_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_vld  = 1'b0;
    ovf_clr = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (disp_data !== 8'h00) begin n_fail++; $display("FAIL reset_disp got %h exp 00", disp_data); end
    n_checks++; if (disp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", disp_busy); end
    n_checks++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", fifo_cnt); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
    tick();
    push(8'hE1);
    push(8'hE2);
    push(8'hE3);
    tick();
    n_checks++; if (disp_data !== 8'hE1) begin n_fail++; $display("FAIL pre_reset_disp got %h exp e1", disp_data); end
    n_checks++; if (fifo_cnt !== 3'd2) begin n_fail++; $display("FAIL pre_reset_cnt got %0d exp 2", fifo_cnt); end
    // Asynchronous assertion between clock edges, with traffic still arriving.
    rx_data = 8'hE4;
    rx_vld  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (disp_data !== 8'h00) begin n_fail++; $display("FAIL async_reset_disp got %h exp 00", disp_data); end
    n_checks++; if (disp_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b exp 0", disp_busy); end
    n_checks++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL async_reset_cnt got %0d exp 0", fifo_cnt); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (disp_data !== 8'h00 || fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL held_reset_%0d disp %h cnt %0d exp 00/0", i, disp_data, fifo_cnt); end
    end
    rx_vld = 1'b0;
    rst_n  = 1'b1;
    tick();
    tick();
    n_checks++; if (disp_data !== 8'h00 || disp_busy !== 1'b0 || fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL post_reset disp %h busy %b cnt %0d exp 00/0/0", disp_data, disp_busy, fifo_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    push(8'hA5);
    n_checks++; if (fifo_cnt !== 3'd1 || disp_busy !== 1'b0) begin n_fail++; $display("FAIL single_push cnt %0d busy %b exp 1/0", fifo_cnt, disp_busy); end
    tick();
    n_checks++; if (disp_data !== 8'hA5 || disp_busy !== 1'b1 || fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL single_load disp %h busy %b cnt %0d exp a5/1/0", disp_data, disp_busy, fifo_cnt); end
    repeat (7) tick();
    n_checks++; if (disp_busy !== 1'b1) begin n_fail++; $display("FAIL single_hold_end busy %b exp 1", disp_busy); end
    tick();
    n_checks++; if (disp_busy !== 1'b0 || disp_data !== 8'hA5) begin n_fail++; $display("FAIL single_idle busy %b disp %h exp 0/a5", disp_busy, disp_data); end
    repeat (3) tick();
    n_checks++; if (disp_data !== 8'hA5) begin n_fail++; $display("FAIL single_keep disp %h exp a5", disp_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    logic       exp_b;
    logic [2:0] peak;
    do_reset();
    peak = 3'd0;
    for (int k = 0; k < 26; k++) begin
      rx_vld  = (k < 3);
      rx_data = 8'(8'h11 * (k + 1));
      tick();
      if (fifo_cnt > peak) peak = fifo_cnt;
      if (k >= 1) begin
        exp_d = (k < 9) ? 8'h11 : (k < 17) ? 8'h22 : 8'h33;
        exp_b = (k < 25);
        n_checks++; if (disp_data !== exp_d || disp_busy !== exp_b) begin n_fail++; $display("FAIL burst_k%0d disp %h busy %b exp %h/%b", k, disp_data, disp_busy, exp_d, exp_b); end
      end
    end
    rx_vld = 1'b0;
    n_checks++; if (peak !== 3'd2) begin n_fail++; $display("FAIL burst_peak got %0d exp 2", peak); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_c;
    do_reset();
    push(8'h40);
    tick();
    for (int i = 0; i < 6; i++) begin
      push(8'(i + 1));
      exp_c = (i < 4) ? 3'(i + 1) : 3'd4;
      n_checks++; if (fifo_cnt !== exp_c || ovf !== (i >= 4)) begin n_fail++; $display("FAIL ovf_push%0d cnt %0d ovf %b exp %0d/%b", i, fifo_cnt, ovf, exp_c, (i >= 4)); end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    tick();
    n_checks++; if (disp_data !== 8'h01 || fifo_cnt !== 3'd3) begin n_fail++; $display("FAIL ovf_pop disp %h cnt %0d exp 01/3", disp_data, fifo_cnt); end
    push(8'h07);
    ovf_clr = 1'b1;
    push(8'h0A);
    ovf_clr = 1'b0;
    n_checks++; if (ovf !== 1'b1 || fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_set_wins ovf %b cnt %0d exp 1/4", ovf, fifo_cnt); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    push(8'h50);
    tick();
    for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
    repeat (3) tick();
    n_checks++; if (fifo_cnt !== 3'd4 || disp_data !== 8'h50) begin n_fail++; $display("FAIL full_pre cnt %0d disp %h exp 4/50", fifo_cnt, disp_data); end
    push(8'h99);
    n_checks++; if (fifo_cnt !== 3'd4 || ovf !== 1'b0 || disp_data !== 8'h61) begin n_fail++; $display("FAIL full_pop_push cnt %0d ovf %b disp %h exp 4/0/61", fifo_cnt, ovf, disp_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      b = 8'(k * 8'h17 + 8'h05);
      push(b);
      if (k > 0) begin
        n_checks++; if (disp_busy !== 1'b0 || fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL wrap_late%0d busy %b cnt %0d exp 0/1", k, disp_busy, fifo_cnt); end
      end
      tick();
      n_checks++; if (disp_data !== b || disp_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_show%0d disp %h busy %b exp %h/1", k, disp_data, disp_busy, b); end
      repeat (7) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
